// File: rtl/puf_pkg.sv
// Shared types and LFSR helpers for the ring-oscillator PUF reader.
// Pure declarations, so there is no latency and no backpressure.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    CMP  = 3'd3,
    FIN  = 3'd4
  } pufState_e;

  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;

  // Right-shifting Galois step; value must already fit in 'width' bits.
  function automatic logic [31:0] lfsr_next(input int width, input logic [31:0] value);
    logic [31:0] taps;
    logic [31:0] nxt;
    case (width)
      8:       taps = {24'h0, LFSR_TAPS_8};
      16:      taps = {16'h0, LFSR_TAPS_16};
      default: taps = LFSR_TAPS_32;
    endcase
    nxt = value >> 1;
    if (value[0]) nxt = nxt ^ taps;
    return nxt;
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronizes one oscillator, detects rising edges, counts them (saturating); 2-cycle edge latency.
// No backpressure: counts only while countEn is high, clear wins over counting.
module ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             osc,
  input  logic             clear,
  input  logic             countEn,
  output logic [CNT_W-1:0] count
);

  logic syncStage1;
  logic syncStage2;
  logic prevSample;
  logic rise;

  assign rise = syncStage2 & ~prevSample;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncStage1 <= 1'b0;
      syncStage2 <= 1'b0;
      prevSample <= 1'b0;
      count      <= '0;
    end else begin
      syncStage1 <= osc;
      syncStage2 <= syncStage1;
      prevSample <= syncStage2;
      if (clear) begin
        count <= '0;
      end else if (countEn && rise && (count != '1)) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ro_puf_reader.sv
// RO-PUF evaluation controller: RESP_W x (SETTLE + WINDOW + 1) cycles per request, done one cycle later.
// start is only honoured in IDLE; requests while busy are dropped, never queued.
module ro_puf_reader
  import puf_pkg::*;
#(
  parameter int CHAL_W = 8,
  parameter int RESP_W = 16,
  parameter int CNT_W  = 16,
  parameter int SETTLE = 4,
  parameter int WINDOW = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2*CHAL_W-1:0] seed,
  input  logic                ro_a,
  input  logic                ro_b,
  output logic [CHAL_W-1:0]   chal_sel,
  output logic [CHAL_W-1:0]   chal_bx,
  output logic                ro_en,
  output logic                busy,
  output logic                done,
  output logic [RESP_W-1:0]   response
);

  localparam int LFSR_W  = 2 * CHAL_W;
  localparam int TMR_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int BIDX_W  = (RESP_W > 1) ? $clog2(RESP_W) : 1;

  localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0]  WINDOW_LAST = TMR_W'(WINDOW - 1);
  localparam logic [BIDX_W-1:0] BIT_LAST    = BIDX_W'(RESP_W - 1);

  pufState_e          state;
  pufState_e          stateNext;
  logic [TMR_W-1:0]   timer;
  logic [BIDX_W-1:0]  bitIdx;
  logic [LFSR_W-1:0]  lfsr;
  logic [LFSR_W-1:0]  lfsrStep;
  logic [CNT_W-1:0]   cntA;
  logic [CNT_W-1:0]   cntB;
  logic               acceptStart;
  logic               lastBit;
  logic               cntClear;
  logic               cntEn;

  assign lfsrStep = LFSR_W'(lfsr_next(LFSR_W, 32'(lfsr)));
  assign chal_sel = lfsr[CHAL_W-1:0];
  assign chal_bx  = lfsr[LFSR_W-1:CHAL_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext   = state;
    acceptStart = 1'b0;
    lastBit     = (bitIdx == BIT_LAST);
    cntClear    = 1'b0;
    cntEn       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          acceptStart = 1'b1;
          stateNext   = LOAD;
        end
      end
      LOAD: begin
        cntClear = 1'b1;
        if (timer == SETTLE_LAST) stateNext = RUN;
      end
      RUN: begin
        cntEn = 1'b1;
        if (timer == WINDOW_LAST) stateNext = CMP;
      end
      CMP: begin
        stateNext = lastBit ? FIN : LOAD;
      end
      FIN: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Control outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ro_en <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      timer <= '0;
    end else begin
      ro_en <= (stateNext == RUN);
      busy  <= (stateNext == LOAD) || (stateNext == RUN) || (stateNext == CMP);
      done  <= (stateNext == FIN);
      if ((stateNext != state) || (state == IDLE)) begin
        timer <= '0;
      end else begin
        timer <= timer + TMR_W'(1);
      end
    end
  end

  // An all-zero seed would lock the LFSR, so it is replaced by all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr     <= '0;
      bitIdx   <= '0;
      response <= '0;
    end else if (acceptStart) begin
      lfsr     <= (seed == '0) ? '1 : seed;
      bitIdx   <= '0;
      response <= '0;
    end else if (state == CMP) begin
      response[bitIdx] <= (cntA > cntB);
      lfsr             <= lfsrStep;
      if (!lastBit) bitIdx <= bitIdx + BIDX_W'(1);
    end
  end

  ro_edge_counter #(.CNT_W(CNT_W)) uCntA (
    .clk     (clk),
    .reset   (reset),
    .osc     (ro_a),
    .clear   (cntClear),
    .countEn (cntEn),
    .count   (cntA)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) uCntB (
    .clk     (clk),
    .reset   (reset),
    .osc     (ro_b),
    .clear   (cntClear),
    .countEn (cntEn),
    .count   (cntB)
  );

endmodule

// File: tb/tb_ro_puf_reader.sv
// Directed bench for ro_puf_reader: timing, challenge sequence, compare, reset, saturation.
// Second instance uses a 4-bit counter to exercise saturation.
module tb_ro_puf_reader;

  localparam int CHAL_W  = 8;
  localparam int RESP_W  = 4;
  localparam int SETTLE  = 4;
  localparam int WINDOW  = 64;
  localparam int BIT_CYC = SETTLE + WINDOW + 1;
  localparam int DONE_AT = 1 + RESP_W * BIT_CYC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic [15:0] seed = 16'h0;
  logic [15:0] seed2 = 16'h0;
  logic roAGen = 1'b0, roBGen = 1'b0, roFast = 1'b0, roSlow = 1'b0;
  logic tieMode = 1'b0;
  int perA = 8;
  int perB = 16;
  logic roA, roB;

  logic [CHAL_W-1:0] chal_sel, chal_bx, chal_sel2, chal_bx2;
  logic ro_en, busy, done, ro_en2, busy2, done2;
  logic [RESP_W-1:0] response, response2;

  int errCnt = 0;
  int chkCnt = 0;
  int satDone;
  int idleDones;
  int idleBusy;

  always #5 clk = ~clk;
  always begin #(perA * 5); roAGen = ~roAGen; end
  always begin #(perB * 5); roBGen = ~roBGen; end
  always begin #10; roFast = ~roFast; end
  always begin #40; roSlow = ~roSlow; end

  assign roA = roAGen;
  assign roB = tieMode ? roAGen : roBGen;

  ro_puf_reader #(.CHAL_W(CHAL_W), .RESP_W(RESP_W), .CNT_W(16), .SETTLE(SETTLE), .WINDOW(WINDOW)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .ro_a(roA), .ro_b(roB),
    .chal_sel(chal_sel), .chal_bx(chal_bx), .ro_en(ro_en), .busy(busy), .done(done),
    .response(response)
  );

  ro_puf_reader #(.CHAL_W(CHAL_W), .RESP_W(RESP_W), .CNT_W(4), .SETTLE(SETTLE), .WINDOW(WINDOW)) dutSat (
    .clk(clk), .reset(reset), .start(start2), .seed(seed2), .ro_a(roFast), .ro_b(roSlow),
    .chal_sel(chal_sel2), .chal_bx(chal_bx2), .ro_en(ro_en2), .busy(busy2), .done(done2),
    .response(response2)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] galois16(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic runEval(input string tag, input logic [15:0] seedV, input logic [15:0] expFirst,
                         input logic [15:0] expSecond, input int pulseAt, input int resetAt);
    logic [15:0] seqv [RESP_W];
    int doneAt, chalErr, phaseErr, bitN, ph;
    seqv[0] = (seedV == 16'h0) ? 16'hFFFF : seedV;
    for (int i = 1; i < RESP_W; i++) seqv[i] = galois16(seqv[i-1]);
    doneAt = -1;
    chalErr = 0;
    phaseErr = 0;
    @(negedge clk);
    seed = seedV;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (c > 1) @(negedge clk);
      if (c == pulseAt + 1) start = 1'b0;
      if (c == pulseAt) begin
        seed = 16'h5A5A;
        start = 1'b1;
      end
      if (c == resetAt) begin
        reset = 1'b1;
        #1;
        checkVal({tag, ".rst_ro_en"}, 32'(ro_en), 32'h0);
        checkVal({tag, ".rst_busy_done"}, {30'h0, busy, done}, 32'h0);
        checkVal({tag, ".rst_chal"}, {16'h0, chal_bx, chal_sel}, 32'h0);
        checkVal({tag, ".rst_response"}, 32'(response), 32'h0);
        break;
      end
      if (c == 1) checkVal({tag, ".chal_first"}, {16'h0, chal_bx, chal_sel}, {16'h0, expFirst});
      if (c == BIT_CYC + 1) checkVal({tag, ".chal_second"}, {16'h0, chal_bx, chal_sel}, {16'h0, expSecond});
      bitN = (c - 1) / BIT_CYC;
      ph = (c - 1) % BIT_CYC;
      if (bitN < RESP_W) begin
        if (ro_en !== ((ph >= SETTLE) && (ph < SETTLE + WINDOW))) phaseErr++;
        if ((busy !== 1'b1) || (done !== 1'b0)) phaseErr++;
        if ({chal_bx, chal_sel} !== seqv[bitN]) chalErr++;
      end
      if (done === 1'b1) begin
        doneAt = c;
        checkVal({tag, ".busy_at_done"}, 32'(busy), 32'h0);
        break;
      end
    end
    if (resetAt == 0) begin
      checkVal({tag, ".done_cycle"}, doneAt, DONE_AT);
      checkVal({tag, ".chal_stable_errs"}, chalErr, 0);
      checkVal({tag, ".phase_errs"}, phaseErr, 0);
      @(negedge clk);
      checkVal({tag, ".done_one_cycle"}, 32'(done), 32'h0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkVal("reset.ctrl", {26'h0, ro_en, busy, done, ro_en2, busy2, done2}, 32'h0);
    checkVal("reset.chal", {16'h0, chal_bx, chal_sel}, 32'h0);
    checkVal("reset.response", {24'h0, response2, response}, 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    runEval("base", 16'h0001, 16'h0001, 16'hB400, 0, 0);
    checkVal("base.response", 32'(response), 32'hF);
    repeat (5) @(negedge clk);

    runEval("busyStart", 16'h0003, 16'h0003, 16'hB401, 100, 0);
    checkVal("busyStart.response", 32'(response), 32'hF);
    idleDones = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) idleDones++;
    end
    checkVal("busyStart.extra_done", idleDones, 0);
    checkVal("busyStart.response_held", 32'(response), 32'hF);

    runEval("midRst", 16'h0001, 16'h0001, 16'hB400, 0, 170);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    idleDones = 0;
    idleBusy = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) idleDones++;
      if (busy) idleBusy++;
    end
    checkVal("midRst.no_done", idleDones, 0);
    checkVal("midRst.idle_busy", idleBusy, 0);
    runEval("afterRst", 16'h0002, 16'h0002, 16'h0001, 0, 0);
    checkVal("afterRst.response", 32'(response), 32'hF);

    perA = 16;
    perB = 8;
    repeat (40) @(negedge clk);
    runEval("swap", 16'h0000, 16'hFFFF, 16'hCBFF, 0, 0);
    checkVal("swap.response", 32'(response), 32'h0);

    tieMode = 1'b1;
    repeat (10) @(negedge clk);
    runEval("tie", 16'h8000, 16'h8000, 16'h4000, 0, 0);
    checkVal("tie.response", 32'(response), 32'h0);

    @(negedge clk);
    seed2 = 16'h00FF;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    checkVal("sat.chal_first", {16'h0, chal_bx2, chal_sel2}, 32'h00FF);
    satDone = -1;
    for (int c = 1; c <= 400; c++) begin
      if (c > 1) @(negedge clk);
      if (done2 === 1'b1) begin
        satDone = c;
        break;
      end
    end
    checkVal("sat.done_cycle", satDone, DONE_AT);
    checkVal("sat.busy_ro_en_at_done", {30'h0, busy2, ro_en2}, 32'h0);
    checkVal("sat.response", 32'(response2), 32'hF);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
